// File: rtl/sram_req_arbiter_pkg.sv
// rtl/sram_req_arbiter_pkg.sv - shared source/size encodings and lock states for the SRAM port arbiter
package sram_req_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int MAX_OUTST_DEF = 4;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_INST = 2'd1,
    LOCK_DATA = 2'd2
  } lock_e;

endpackage

// File: rtl/sram_req_arbiter_src_fifo.sv
// rtl/sram_req_arbiter_src_fifo.sv - 1-bit in-order FIFO remembering which requester owns each outstanding transaction
module src_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             din,
  input  logic             pop,
  output logic             head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0] slots;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - data-first arbiter sharing one SRAM-like port between fetch and load/store
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = MAX_OUTST_DEF,
  parameter int OUTST_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_req,
  input  logic [31:0]      inst_addr,
  output logic             inst_addr_ok,
  output logic [31:0]      inst_rdata,
  output logic             inst_data_ok,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  input  logic [3:0]       data_wstrb,
  output logic             data_addr_ok,
  output logic [31:0]      data_rdata,
  output logic             data_data_ok,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [1:0]       mem_size,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_addr_ok,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_data_ok,
  output logic [OUTST_W:0] outst_cnt,
  output logic             resp_err
);

  lock_e lock_state;
  logic  sel_src;
  logic  sel_req;
  logic  issue;
  logic  fifo_head;
  logic  fifo_full;
  logic  fifo_empty;
  logic  resp_valid;

  // A pending grant keeps its source until the address handshake finishes.
  always_comb begin
    sel_src = data_req ? SRC_DATA : SRC_INST;
    if (lock_state == LOCK_DATA) sel_src = SRC_DATA;
    if (lock_state == LOCK_INST) sel_src = SRC_INST;
  end

  assign sel_req      = (sel_src == SRC_DATA) ? data_req : inst_req;
  assign mem_req      = sel_req & ~fifo_full;
  assign issue        = mem_req & mem_addr_ok;
  assign inst_addr_ok = issue & (sel_src == SRC_INST);
  assign data_addr_ok = issue & (sel_src == SRC_DATA);

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    if (sel_req) begin
      if (sel_src == SRC_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        mem_wstrb = data_wstrb;
      end else begin
        mem_size  = SIZE_W;
        mem_addr  = inst_addr;
      end
    end
  end

  // Dropping the locked request leaves mem_req low, which releases the lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state <= LOCK_NONE;
    end else if (mem_req && !mem_addr_ok) begin
      lock_state <= (sel_src == SRC_DATA) ? LOCK_DATA : LOCK_INST;
    end else begin
      lock_state <= LOCK_NONE;
    end
  end

  src_fifo #(
    .DEPTH (MAX_OUTST),
    .PTR_W (OUTST_W)
  ) u_src_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (issue),
    .din   (sel_src),
    .pop   (resp_valid),
    .head  (fifo_head),
    .count (outst_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign resp_valid   = mem_data_ok & ~fifo_empty;
  assign inst_data_ok = resp_valid & (fifo_head == SRC_INST);
  assign data_data_ok = resp_valid & (fifo_head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_err <= 1'b0;
    end else if (mem_data_ok && fifo_empty) begin
      resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - scoreboard bench for the SRAM port arbiter
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok;
  logic [31:0] mem_rdata;
  logic        mem_data_ok;
  logic [2:0]  outst_cnt;
  logic        resp_err;

  int   n_vec = 0;
  int   n_err = 0;
  logic sb[$];
  logic exp_err;

  sram_req_arbiter #(.MAX_OUTST(4), .OUTST_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_addr_ok  (mem_addr_ok),
    .mem_rdata    (mem_rdata),
    .mem_data_ok  (mem_data_ok),
    .outst_cnt    (outst_cnt),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    inst_req    = 1'b0;
    inst_addr   = 32'd0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_addr   = 32'd0;
    data_wdata  = 32'd0;
    data_wstrb  = 4'd0;
    mem_addr_ok = 1'b0;
    mem_rdata   = 32'd0;
    mem_data_ok = 1'b0;
  endtask

  // Called with inputs settled; checks grants and response routing, updates the model, advances a cycle.
  task automatic tick(input logic e_iok, input logic e_dok);
    logic s;
    chk("outst_cnt", 32'(outst_cnt), 32'(sb.size()));
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iok));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(e_dok));
    if (mem_data_ok) begin
      if (sb.size() != 0) begin
        s = sb.pop_front();
        chk("inst_data_ok", 32'(inst_data_ok), 32'(!s));
        chk("data_data_ok", 32'(data_data_ok), 32'(s));
        chk("rdata", s ? data_rdata : inst_rdata, mem_rdata);
      end else begin
        chk("stray inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("stray data_data_ok", 32'(data_data_ok), 32'd0);
        exp_err = 1'b1;
      end
    end
    if (e_iok) sb.push_back(1'b0);
    if (e_dok) sb.push_back(1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic e_iok, input logic e_dok);
    #2;
    tick(e_iok, e_dok);
  endtask

  task automatic resp(input logic [31:0] v);
    mem_data_ok = 1'b1;
    mem_rdata   = v;
    step(1'b0, 1'b0);
    mem_data_ok = 1'b0;
  endtask

  initial begin
    idle();
    exp_err = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_size", 32'(mem_size), 32'd0);
    chk("rst outst_cnt", 32'(outst_cnt), 32'd0);
    reset = 1'b0;
    repeat (5) begin
      #2;
      chk("idle mem_req", 32'(mem_req), 32'd0);
      tick(1'b0, 1'b0);
    end

    // contention: data wins, inst follows
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    data_req = 1'b1; data_addr = 32'h100; data_size = 2'd2;
    mem_addr_ok = 1'b1;
    #2;
    chk("cont mem_addr", mem_addr, 32'h100);
    tick(1'b0, 1'b1);
    data_req = 1'b0;
    #2;
    chk("cont2 mem_addr", mem_addr, 32'hBFC0_0000);
    chk("cont2 mem_size", 32'(mem_size), 32'd2);
    tick(1'b1, 1'b0);
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    resp(32'h11);
    resp(32'h22);
    step(1'b0, 1'b0);

    // lock hold: inst keeps the port until its handshake, despite data arriving
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    #2;
    chk("lock1 mem_addr", mem_addr, 32'hBFC0_0010);
    tick(1'b0, 1'b0);
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h300;
    data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'hF; data_size = 2'd2;
    #2;
    chk("lock2 mem_addr", mem_addr, 32'hBFC0_0010);
    chk("lock2 mem_wr", 32'(mem_wr), 32'd0);
    tick(1'b0, 1'b0);
    #2;
    chk("lock3 mem_addr", mem_addr, 32'hBFC0_0010);
    tick(1'b0, 1'b0);
    mem_addr_ok = 1'b1;
    #2;
    chk("lock4 mem_addr", mem_addr, 32'hBFC0_0010);
    tick(1'b1, 1'b0);
    inst_req = 1'b0;
    #2;
    chk("store mem_addr", mem_addr, 32'h300);
    chk("store mem_wr", 32'(mem_wr), 32'd1);
    chk("store mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("store mem_wstrb", 32'(mem_wstrb), 32'hF);
    tick(1'b0, 1'b1);
    data_req = 1'b0; data_wr = 1'b0; mem_addr_ok = 1'b0;
    resp(32'h33);
    resp(32'h44);

    // in-order routing, including an issue in the same cycle as a response
    mem_addr_ok = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    step(1'b1, 1'b0);
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h200;
    step(1'b0, 1'b1);
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    step(1'b1, 1'b0);
    inst_addr = 32'hBFC0_0008; mem_data_ok = 1'b1; mem_rdata = 32'hA;
    step(1'b1, 1'b0);
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_rdata = 32'hB; step(1'b0, 1'b0);
    mem_rdata = 32'hC; step(1'b0, 1'b0);
    mem_rdata = 32'hD; step(1'b0, 1'b0);
    mem_data_ok = 1'b0;
    step(1'b0, 1'b0);

    // full: issue blocked, even in the cycle a response pops
    data_req = 1'b1; data_wr = 1'b1; mem_addr_ok = 1'b1; data_wstrb = 4'h3;
    for (int i = 0; i < 4; i++) begin
      data_addr = 32'h400 + 32'(i * 4);
      step(1'b0, 1'b1);
    end
    #2;
    chk("full mem_req", 32'(mem_req), 32'd0);
    tick(1'b0, 1'b0);
    mem_data_ok = 1'b1; mem_rdata = 32'h55;
    #2;
    chk("full+pop mem_req", 32'(mem_req), 32'd0);
    tick(1'b0, 1'b0);
    mem_data_ok = 1'b0;
    #2;
    chk("refill mem_req", 32'(mem_req), 32'd1);
    tick(1'b0, 1'b1);
    data_req = 1'b0; data_wr = 1'b0; mem_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) resp(32'h60 + 32'(i));
    step(1'b0, 1'b0);

    // reset drops outstanding state; a late response is flagged
    mem_addr_ok = 1'b1; inst_req = 1'b1; inst_addr = 32'hBFC0_0020;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    exp_err = 1'b0;
    resp(32'h66);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
Shares one SRAM-like memory port between the instruction-fetch requester (read-only) and the data requester (load/store from EXE, response consumed in MEM). Performs fixed-priority arbitration with data first, and holds a grant until the address handshake completes. Tracks the source of up to MAX_OUTST in-order outstanding transactions so each data_ok/rdata is routed back to the requester that issued it. Sits between the pipeline stages and the memory bridge.

Parameters:
MAX_OUTST, 4, maximum accepted-but-unanswered transactions; power of two, >=2
OUTST_W, 2, log2(MAX_OUTST); width of FIFO pointers (count is OUTST_W+1 bits)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_req  in  1  fetch request valid
inst_addr  in  32  fetch address (always word read, size=2)
inst_addr_ok  out  1  fetch request accepted this cycle
inst_rdata  out  32  fetch read data
inst_data_ok  out  1  fetch response valid
data_req  in  1  data request valid
data_wr  in  1  1=store, 0=load
data_size  in  2  0=byte, 1=half, 2=word
data_addr  in  32  data address
data_wdata  in  32  store data
data_wstrb  in  4  store byte enables
data_addr_ok  out  1  data request accepted this cycle
data_rdata  out  32  load data
data_data_ok  out  1  data response valid (loads and store acks)
mem_req  out  1  downstream request valid
mem_wr  out  1  downstream write
mem_size  out  2  downstream size
mem_addr  out  32  downstream address
mem_wdata  out  32  downstream write data
mem_wstrb  out  4  downstream byte enables
mem_addr_ok  in  1  downstream accepts request
mem_rdata  in  32  downstream read data
mem_data_ok  in  1  downstream response valid
outst_cnt  out  OUTST_W+1  current outstanding count
resp_err  out  1  sticky: mem_data_ok received while nothing outstanding

Behaviour:
- Reset: FIFO empty, outst_cnt=0, lock cleared, resp_err=0. All outputs are 0 during and after reset while inputs are idle.
- full = (outst_cnt==MAX_OUTST). While full, mem_req=0 and both *_addr_ok=0; requests stay pending.
- Selection when not locked: data_req wins; otherwise inst_req. No round-robin.
- Lock: if mem_req=1 and mem_addr_ok=0, register lock_valid=1 and lock_src=selected. While locked, the selection is lock_src regardless of the other request. Lock clears on the cycle mem_addr_ok=1, or if the locked requester drops req (protocol violation; no issue occurs).
- mem_* fields are combinationally muxed from the selected source. For inst: wr=0, size=2, wstrb=0, wdata=0.
- Issue = mem_req & mem_addr_ok. The granted requester's *_addr_ok equals issue, same cycle (zero latency). On issue, push the source bit (0=inst, 1=data) into the FIFO.
- Response: on mem_data_ok with FIFO non-empty, pop the head. Head=1 drives data_data_ok=1 and data_rdata=mem_rdata; head=0 drives the inst pair. Both are combinational, same cycle. The non-selected *_data_ok is 0. rdata outputs pass mem_rdata unconditionally.
- Simultaneous issue and response: push and pop in the same cycle, count unchanged. Response routing uses the head before the push. A response can never be routed to the transaction issued in the same cycle.
- A full FIFO blocks issue even if a pop occurs the same cycle. This keeps full off the data_ok→addr_ok combinational path.
- mem_data_ok with an empty FIFO: ignored, no *_data_ok pulse, resp_err set until reset.
- Pointers wrap modulo MAX_OUTST. Count is OUTST_W+1 bits wide so it can reach MAX_OUTST.
- Reset mid-transaction: all outstanding state is dropped. Late responses after reset set resp_err (the system flushes memory alongside).

Decomposition:
- Shared header (mycpu.h): SRC_INST=1'b0, SRC_DATA=1'b1, size encodings (SIZE_B/H/W), default MAX_OUTST.
- One sub-module: src_fifo. A synchronous 1-bit-wide FIFO of depth MAX_OUTST with push, pop, head, count, full and empty. The top level holds the arbitration/lock logic and the muxes.

Test Plan:
- Idle after reset: all req=0 for 5 cycles -> mem_req=0, outst_cnt=0, resp_err=0.
- Contention: inst_req and data_req both high, data_addr=0x100, mem_addr_ok=1 -> mem_addr=0x100, data_addr_ok=1, inst_addr_ok=0. The next cycle with only inst pending -> inst_addr_ok=1.
- Lock hold: inst_req alone, mem_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays the inst address until mem_addr_ok=1. Only then is data granted.
- Ordering: issue inst(0xBFC00000), data load(0x200), inst(0xBFC00004), then 3 mem_data_ok with rdata 0xA, 0xB, 0xC -> inst_data_ok/0xA, data_data_ok/0xB, inst_data_ok/0xC.
- Full/backpressure: issue 4 requests with no response -> outst_cnt=4, mem_req=0 with data_req=1. One mem_data_ok in that cycle -> the next cycle issues again.
- Error and reset: 2 outstanding, assert reset 1 cycle, then mem_data_ok -> no *_data_ok pulse, resp_err=1, outst_cnt=0.
